// File: rtl/scmp_clkseq_pkg.sv
// Shared types for the SC/MP clock-enable / reset sequencer: FSM states and LED encoding.
package scmp_clkseq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } seq_state_t;

  localparam logic [1:0] LED_WAIT_LOCK = 2'd0;
  localparam logic [1:0] LED_HOLD      = 2'd1;
  localparam logic [1:0] LED_RUN       = 2'd2;

  function automatic logic [1:0] seq_led(input seq_state_t s);
    case (s)
      WAIT_LOCK: return LED_WAIT_LOCK;
      HOLD:      return LED_HOLD;
      RUN:       return LED_RUN;
      default:   return LED_WAIT_LOCK;
    endcase
  endfunction

endpackage

// File: rtl/scmp_clkseq_debounce.sv
// Two-flop synchroniser followed by a stable-run counter; o_db follows the synced
// input only after it has differed from o_db for CYCLES consecutive cycles.
module scmp_clkseq_debounce #(
  parameter int CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_db
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= i_raw;
      r_sync1 <= r_sync0;
      // Any cycle where the input agrees with the output restarts the run.
      if (r_sync1 != r_db) begin
        if (r_cnt == CNT_LAST) begin
          r_db  <= r_sync1;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/scmp_clk_rst_seq.sv
// SC/MP clock-enable and reset sequencer: PLL-lock wait, button debounce, micro-cycle
// divider and core reset hold. Optional single-step support under SCMP_CLKSEQ_STEP_EN.
module scmp_clk_rst_seq
  import scmp_clkseq_pkg::*;
#(
  parameter int CLK_DIV         = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_UCYCLES    = 8
) (
  input  logic                       i_sys_clk,
  input  logic                       i_reset,
  input  logic                       i_pll_lock,
  input  logic                       i_btn_raw,
`ifdef SCMP_CLKSEQ_STEP_EN
  input  logic                       i_step_mode,
  input  logic                       i_step_btn,
`endif
  output logic                       o_clk_en,
  output logic [$clog2(CLK_DIV)-1:0] o_phase,
  output logic                       o_core_reset,
  output logic [1:0]                 o_seq_state
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int HW = (HOLD_UCYCLES > 1) ? $clog2(HOLD_UCYCLES) : 1;
  localparam logic [PW-1:0] PH_LAST   = PW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_UCYCLES - 1);

  logic          r_lock_s0;
  logic          r_lock_s1;
  seq_state_t    r_state;
  logic [PW-1:0] r_phase;
  logic          r_clk_en;
  logic          r_core_reset;
  logic [HW-1:0] r_hold_cnt;

  logic          w_btn_db;
  logic          w_div_hold;
  logic          w_stall;
  logic [PW-1:0] w_phase_nxt;
  logic          w_clk_en_nxt;

  scmp_clkseq_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .i_clk (i_sys_clk),
    .i_rst (i_reset),
    .i_raw (i_btn_raw),
    .o_db  (w_btn_db)
  );

`ifdef SCMP_CLKSEQ_STEP_EN
  logic w_step_db;
  logic r_step_db_d;
  logic r_step_go;

  scmp_clkseq_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .i_clk (i_sys_clk),
    .i_rst (i_reset),
    .i_raw (i_step_btn),
    .o_db  (w_step_db)
  );

  // A step press arms one micro-cycle; it is consumed when the divider leaves phase 0.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_step_db_d <= 1'b0;
      r_step_go   <= 1'b0;
    end else begin
      r_step_db_d <= w_step_db;
      if (r_state != RUN)
        r_step_go <= 1'b0;
      else if (w_step_db && !r_step_db_d)
        r_step_go <= 1'b1;
      else if (r_phase == '0)
        r_step_go <= 1'b0;
    end
  end

  assign w_stall = (r_state == RUN) && i_step_mode && (r_phase == '0) && !r_step_go;
`else
  assign w_stall = 1'b0;
`endif

  // Divider is parked at phase 0 while waiting for lock and on the edge lock is lost.
  assign w_div_hold   = (r_state == WAIT_LOCK) || !r_lock_s1;
  assign w_phase_nxt  = (w_div_hold || w_stall || r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
  assign w_clk_en_nxt = (w_phase_nxt == PH_LAST);

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lock_s0    <= 1'b0;
      r_lock_s1    <= 1'b0;
      r_state      <= WAIT_LOCK;
      r_phase      <= '0;
      r_clk_en     <= 1'b0;
      r_core_reset <= 1'b1;
      r_hold_cnt   <= '0;
    end else begin
      r_lock_s0 <= i_pll_lock;
      r_lock_s1 <= r_lock_s0;
      r_phase   <= w_phase_nxt;
      r_clk_en  <= w_clk_en_nxt;
      if (!r_lock_s1) begin
        r_state      <= WAIT_LOCK;
        r_core_reset <= 1'b1;
        r_hold_cnt   <= '0;
      end else begin
        case (r_state)
          WAIT_LOCK: begin
            r_state      <= HOLD;
            r_core_reset <= 1'b1;
            r_hold_cnt   <= '0;
          end
          HOLD: begin
            if (w_btn_db) begin
              r_hold_cnt <= '0;
            end else if (r_clk_en) begin
              if (r_hold_cnt == HOLD_LAST) begin
                r_state      <= RUN;
                r_core_reset <= 1'b0;
                r_hold_cnt   <= '0;
              end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
              end
            end
          end
          RUN: begin
            if (w_btn_db) begin
              r_state      <= HOLD;
              r_core_reset <= 1'b1;
              r_hold_cnt   <= '0;
            end
          end
          default: begin
            r_state      <= WAIT_LOCK;
            r_core_reset <= 1'b1;
            r_hold_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_clk_en     = r_clk_en;
  assign o_phase      = r_phase;
  assign o_core_reset = r_core_reset;
  assign o_seq_state  = seq_led(r_state);

endmodule

// File: tb/tb_scmp_clk_rst_seq.sv
// Self-checking bench for scmp_clk_rst_seq (default build, SCMP_CLKSEQ_STEP_EN undefined).
module tb_scmp_clk_rst_seq;

  localparam int CLK_DIV = 4;
  localparam int DEB     = 16;
  localparam int HOLD    = 8;
  localparam int PW      = $clog2(CLK_DIV);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pll_lock = 1'b0;
  logic          btn_raw = 1'b0;
  logic          o_clk_en;
  logic [PW-1:0] o_phase;
  logic          o_core_reset;
  logic [1:0]    o_seq_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  scmp_clk_rst_seq #(.CLK_DIV(CLK_DIV), .DEBOUNCE_CYCLES(DEB), .HOLD_UCYCLES(HOLD)) dut (
    .i_sys_clk    (clk),
    .i_reset      (rst),
    .i_pll_lock   (pll_lock),
    .i_btn_raw    (btn_raw),
    .o_clk_en     (o_clk_en),
    .o_phase      (o_phase),
    .o_core_reset (o_core_reset),
    .o_seq_state  (o_seq_state)
  );

  // Reference model: inputs seen through a two-sample delay line, a run-length glitch
  // filter, elapsed-time divider and micro-cycle counting in HOLD.
  bit lq[$] = '{1'b0, 1'b0};
  bit bq[$] = '{1'b0, 1'b0};
  int m_state = 0, m_elapsed = 0, m_ucyc = 0, m_run = 0;
  bit m_db = 1'b0;
  bit mt_ls, mt_bs, mt_db, mt_en;
  int mt_st;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lq = '{1'b0, 1'b0};
      bq = '{1'b0, 1'b0};
      m_state = 0; m_elapsed = 0; m_ucyc = 0; m_run = 0; m_db = 1'b0;
    end else begin
      mt_ls = lq[0];
      mt_bs = bq[0];
      lq.push_back(pll_lock); void'(lq.pop_front());
      bq.push_back(btn_raw);  void'(bq.pop_front());
      mt_st = m_state;
      mt_db = m_db;
      mt_en = (mt_st != 0) && (m_elapsed % CLK_DIV == CLK_DIV - 1);
      if (mt_bs != m_db) begin
        m_run++;
        if (m_run == DEB) begin m_db = mt_bs; m_run = 0; end
      end else m_run = 0;
      if (mt_st == 0 || !mt_ls) m_elapsed = 0; else m_elapsed++;
      if (!mt_ls) begin m_state = 0; m_ucyc = 0; end
      else if (mt_st == 0) begin m_state = 1; m_ucyc = 0; end
      else if (mt_st == 1) begin
        if (mt_db) m_ucyc = 0;
        else if (mt_en) begin
          m_ucyc++;
          if (m_ucyc == HOLD) begin m_state = 2; m_ucyc = 0; end
        end
      end else if (mt_db) begin m_state = 1; m_ucyc = 0; end
    end
  end

  logic [PW+3:0] exp_vec, obs_vec;
  always_comb begin
    exp_vec = {(m_state != 0) && (m_elapsed % CLK_DIV == CLK_DIV - 1),
               PW'(m_elapsed % CLK_DIV), m_state != 2, 2'(m_state)};
    obs_vec = {o_clk_en, o_phase, o_core_reset, o_seq_state};
  end

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (o_clk_en !== 1'b0) begin n_errors++; $display("FAIL rst_clk_en got %b want 0", o_clk_en); end
    n_checks++; if (o_phase !== '0) begin n_errors++; $display("FAIL rst_phase got %0d want 0", o_phase); end
    n_checks++; if (o_core_reset !== 1'b1) begin n_errors++; $display("FAIL rst_core_reset got %b want 1", o_core_reset); end
    n_checks++; if (o_seq_state !== 2'd0) begin n_errors++; $display("FAIL rst_seq_state got %0d want 0", o_seq_state); end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== {1'b0, PW'(0), 1'b1, 2'd0}) begin
        n_errors++; $display("FAIL powerup_idle t=%0t got %h want %h", $time, obs_vec, {1'b0, PW'(0), 1'b1, 2'd0});
      end
      n_checks++; if (obs_vec !== exp_vec) begin n_errors++; $display("FAIL model_reset t=%0t got %h want %h", $time, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_lock();
    int hold_at = -1, fall_at = -1, pulses = 0, first_p = -1, last_p = -1;
    logic [PW-1:0] ph_fall = '1;
    pll_lock = 1'b1;
    for (int e = 1; e <= 100 && fall_at < 0; e++) begin
      @(negedge clk);
      n_checks++; if (obs_vec !== exp_vec) begin n_errors++; $display("FAIL model_lock t=%0t got %h want %h", $time, obs_vec, exp_vec); end
      if (hold_at < 0 && o_seq_state == 2'd1) hold_at = e;
      if (o_clk_en && o_core_reset) begin
        pulses++;
        if (first_p < 0) first_p = e;
        last_p = e;
      end
      if (!o_core_reset) begin fall_at = e; ph_fall = o_phase; end
    end
    n_checks++; if (hold_at != 3) begin n_errors++; $display("FAIL lock_to_hold edges got %0d want 3", hold_at); end
    n_checks++; if (fall_at != 3 + CLK_DIV * HOLD) begin n_errors++; $display("FAIL lock_to_run edges got %0d want %0d", fall_at, 3 + CLK_DIV * HOLD); end
    n_checks++; if (ph_fall !== '0) begin n_errors++; $display("FAIL run_phase got %0d want 0", ph_fall); end
    n_checks++; if (pulses != HOLD) begin n_errors++; $display("FAIL hold_pulses got %0d want %0d", pulses, HOLD); end
    n_checks++; if (last_p - first_p != CLK_DIV * (HOLD - 1)) begin n_errors++; $display("FAIL pulse_span got %0d want %0d", last_p - first_p, CLK_DIV * (HOLD - 1)); end
  endtask

  task automatic test_button();
    int hold_at = -1, fall_at = -1, pulses = 0, runlen = 0;
    btn_raw = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) btn_raw = 1'b0;
      @(negedge clk);
      n_checks++; if (o_seq_state !== 2'd2) begin n_errors++; $display("FAIL short_press state got %0d want 2", o_seq_state); end
      n_checks++; if (obs_vec !== exp_vec) begin n_errors++; $display("FAIL model_short t=%0t got %h want %h", $time, obs_vec, exp_vec); end
    end
    btn_raw = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      n_checks++; if (obs_vec !== exp_vec) begin n_errors++; $display("FAIL model_long t=%0t got %h want %h", $time, obs_vec, exp_vec); end
      if (hold_at < 0 && o_seq_state == 2'd1) hold_at = e;
    end
    n_checks++; if (hold_at != 2 + DEB + 1) begin n_errors++; $display("FAIL press_to_hold edges got %0d want %0d", hold_at, 2 + DEB + 1); end
    btn_raw = 1'b0;
    for (int e = 1; e <= 200 && fall_at < 0; e++) begin
      @(negedge clk);
      n_checks++; if (obs_vec !== exp_vec) begin n_errors++; $display("FAIL model_release t=%0t got %h want %h", $time, obs_vec, exp_vec); end
      if (o_clk_en && o_seq_state == 2'd1 && !m_db) pulses++;
      if (!o_core_reset) fall_at = e;
    end
    n_checks++; if (fall_at < 2 + DEB) begin n_errors++; $display("FAIL release_to_run edges got %0d want >= %0d", fall_at, 2 + DEB); end
    n_checks++; if (pulses != HOLD) begin n_errors++; $display("FAIL release_pulses got %0d want %0d", pulses, HOLD); end
    for (int i = 0; i < 200; i++) begin
      if (runlen == 0) begin btn_raw = ~btn_raw; runlen = $urandom_range(1, DEB - 3); end
      runlen--;
      @(negedge clk);
      n_checks++; if (o_seq_state !== 2'd2) begin n_errors++; $display("FAIL bounce state got %0d want 2", o_seq_state); end
      n_checks++; if (obs_vec !== exp_vec) begin n_errors++; $display("FAIL model_bounce t=%0t got %h want %h", $time, obs_vec, exp_vec); end
    end
    btn_raw = 1'b0;
    repeat (DEB + 4) @(negedge clk);
  endtask

  task automatic test_lock_loss();
    int lost_at;
    for (int pass = 0; pass < 2; pass++) begin
      pll_lock = 1'b0;
      repeat (5) @(negedge clk);
      pll_lock = 1'b1;
      for (int e = 0; e < 100 && (pass == 0 ? (o_seq_state != 2'd1) : o_core_reset); e++) @(negedge clk);
      repeat (7) @(negedge clk);
      n_checks++;
      if (o_seq_state !== (pass == 0 ? 2'd1 : 2'd2)) begin n_errors++; $display("FAIL pre_loss state got %0d want %0d", o_seq_state, pass + 1); end
      pll_lock = 1'b0;
      lost_at = -1;
      for (int e = 1; e <= 10 && lost_at < 0; e++) begin
        @(negedge clk);
        n_checks++; if (obs_vec !== exp_vec) begin n_errors++; $display("FAIL model_loss t=%0t got %h want %h", $time, obs_vec, exp_vec); end
        if (o_seq_state == 2'd0) lost_at = e;
      end
      n_checks++; if (lost_at != 3) begin n_errors++; $display("FAIL loss_edges pass %0d got %0d want 3", pass, lost_at); end
      n_checks++; if (o_core_reset !== 1'b1 || o_phase !== '0) begin n_errors++; $display("FAIL loss_outputs got rst=%b ph=%0d want rst=1 ph=0", o_core_reset, o_phase); end
    end
    pll_lock = 1'b1;
    for (int e = 0; e < 100 && o_core_reset; e++) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int run_at = -1;
    for (int e = 0; e < 20 && !(o_phase == PW'(2) && o_seq_state == 2'd2); e++) @(negedge clk);
    n_checks++; if (o_phase !== PW'(2) || o_seq_state !== 2'd2) begin n_errors++; $display("FAIL async_setup got ph=%0d st=%0d want ph=2 st=2", o_phase, o_seq_state); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({o_clk_en, o_phase, o_core_reset, o_seq_state} !== {1'b0, PW'(0), 1'b1, 2'd0}) begin
      n_errors++; $display("FAIL async_reset got %h want %h", obs_vec, {1'b0, PW'(0), 1'b1, 2'd0});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 100 && run_at < 0; e++) begin
      @(negedge clk);
      n_checks++; if (obs_vec !== exp_vec) begin n_errors++; $display("FAIL model_restart t=%0t got %h want %h", $time, obs_vec, exp_vec); end
      if (!o_core_reset) run_at = e;
    end
    n_checks++; if (run_at != 3 + CLK_DIV * HOLD) begin n_errors++; $display("FAIL restart_to_run got %0d want %0d", run_at, 3 + CLK_DIV * HOLD); end
  endtask

  task automatic test_random();
    int runlen = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) pll_lock = ~pll_lock;
      if (!pll_lock && $urandom_range(0, 19) == 0) pll_lock = 1'b1;
      if (runlen == 0) begin btn_raw = ~btn_raw; runlen = $urandom_range(1, 3 * DEB); end
      runlen--;
      @(negedge clk);
      n_checks++; if (obs_vec !== exp_vec) begin n_errors++; $display("FAIL model_random t=%0t got %h want %h", $time, obs_vec, exp_vec); end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_button();
    test_lock_loss();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
